// File: rtl/fnd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// fnd_scan_ctrl
//
// Purpose:
//   Time-multiplexes the Basys3 4-digit common-anode 7-segment display.
//   A prescaler produces a one-cycle scan tick every DIV = CLK_HZ/SCAN_HZ
//   clocks. Each tick advances a 2-bit digit index 0->1->2->3->0. The active
//   digit's value is taken from the time fields and decoded to segments.
//   The digit enable, segments and decimal point are registered, so the
//   outputs lag the index and the inputs by one clock.
//
// Parameters:
//   CLK_HZ   system clock frequency
//   SCAN_HZ  digit-advance rate (DIV = CLK_HZ/SCAN_HZ, integer, >= 2)
//
// Ports:
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  synchronous active-low reset
//   mode      in   1  0 = sec.msec, 1 = hour.min
//   msec      in   7  centiseconds (0..99 nominal)
//   sec       in   6  seconds (0..59 nominal)
//   min       in   6  minutes (0..59 nominal)
//   hour      in   5  hours (0..23 nominal)
//   dot       in   4  active-low DP per digit, bit0 = rightmost digit
//   fnd_com   out  4  active-low digit enables, bit0 = rightmost digit
//   fnd_data  out  8  active-low segments {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module fnd_scan_ctrl #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    input  logic [3:0] dot,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Active-low g..a pattern for one decimal digit; 10..15 are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Tens digit of a field. Values 100..127 give 10..12, which the decoder
    // blanks instead of wrapping.
    function automatic logic [3:0] tens_of(input logic [6:0] v);
        logic [6:0] q;
        q = v / 7'd10;
        return q[3:0];
    endfunction

    function automatic logic [3:0] units_of(input logic [6:0] v);
        logic [6:0] r;
        r = v % 7'd10;
        return r[3:0];
    endfunction

    logic [CW-1:0] cnt;
    logic          tick;
    logic [1:0]    idx;

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= 2'd0;
        end else if (tick) begin
            idx <= idx + 2'd1;
        end
    end

    // ---- stage p0: select and decode the digit addressed by idx ----
    logic [6:0] hi_p0;
    logic [6:0] lo_p0;
    logic [3:0] digit_p0;
    logic [6:0] seg_p0;
    logic       dp_p0;
    logic [3:0] com_p0;

    always_comb begin
        hi_p0 = mode ? {2'b00, hour} : {1'b0, sec};
        lo_p0 = mode ? {1'b0, min}   : msec;
    end

    always_comb begin
        digit_p0 = 4'd0;
        case (idx)
            2'd0: digit_p0 = units_of(lo_p0);
            2'd1: digit_p0 = tens_of(lo_p0);
            2'd2: digit_p0 = units_of(hi_p0);
            2'd3: digit_p0 = tens_of(hi_p0);
            default: digit_p0 = 4'd0;
        endcase
    end

    always_comb begin
        seg_p0 = seg_decode(digit_p0);
        dp_p0  = dot[idx];
        com_p0 = ~(4'b0001 << idx);
    end

    // ---- stage p1: registered pin drivers ----
    logic [3:0] com_p1;
    logic [7:0] data_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            com_p1  <= 4'b1111;
            data_p1 <= 8'hFF;
        end else begin
            com_p1  <= com_p0;
            data_p1 <= {dp_p0, seg_p0};
        end
    end

    assign fnd_com  = com_p1;
    assign fnd_data = data_p1;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
module tb_fnd_scan_ctrl;

    localparam int CLK_HZ  = 8;
    localparam int SCAN_HZ = 2;
    localparam int DIV     = CLK_HZ / SCAN_HZ;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [3:0] dot;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    int n_checks = 0;
    int n_fail   = 0;

    fnd_scan_ctrl #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .msec     (msec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .dot      (dot),
        .fnd_com  (fnd_com),
        .fnd_data (fnd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: digit position follows from the number of clocks since
    // reset release; digit value is plain decimal arithmetic on the fields.
    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    int         cyc = 0;
    bit         model_vld = 1'b0;
    logic [3:0] exp_com;
    logic [7:0] exp_data;

    always @(posedge clk) begin
        int i, hi, lo, d;
        model_vld = 1'b1;
        if (!rst_n) begin
            cyc      = 0;
            exp_com  = 4'hF;
            exp_data = 8'hFF;
        end else begin
            i   = (cyc / DIV) % 4;
            cyc = cyc + 1;
            hi  = mode ? int'(hour) : int'(sec);
            lo  = mode ? int'(min)  : int'(msec);
            case (i)
                0: d = lo % 10;
                1: d = lo / 10;
                2: d = hi % 10;
                default: d = hi / 10;
            endcase
            exp_com  = 4'hF & ~(4'h1 << i);
            exp_data = {dot[i], (d <= 9) ? ref_seg(d) : 7'h7F};
        end
    end

    always @(negedge clk) begin
        if (model_vld) begin
            check("model_com", {28'd0, fnd_com}, {28'd0, exp_com});
            check("model_data", {24'd0, fnd_data}, {24'd0, exp_data});
            if (exp_com != 4'hF)
                check("onehot_com", $countones(fnd_com), 3);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [3:0] seq_exp;
        rst_n = 1'b0;
        mode  = 1'b0;
        msec  = 7'd0;
        sec   = 6'd0;
        min   = 6'd0;
        hour  = 5'd0;
        dot   = 4'hF;

        // Reset held for 3 clocks
        wait_clk(3);
        check("rst_com", {28'd0, fnd_com}, 32'hF);
        check("rst_data", {24'd0, fnd_data}, 32'hFF);

        // Release: first edge shows digit 0 (k = 1)
        rst_n = 1'b1;
        wait_clk(1);
        check("first_com", {28'd0, fnd_com}, 32'hE);

        // Scan order, 4 clocks per digit, wrap at k = 17
        for (int k = 2; k <= 17; k++) begin
            wait_clk(1);
            seq_exp = (k <= 4) ? 4'hE : (k <= 8) ? 4'hD : (k <= 12) ? 4'hB :
                      (k <= 16) ? 4'h7 : 4'hE;
            check("scan_seq", {28'd0, fnd_com}, {28'd0, seq_exp});
        end

        // sec.msec = 37.05, dot on digit 0 only (k = 18 .. 29)
        mode = 1'b0; sec = 6'd37; msec = 7'd5; dot = 4'hE;
        wait_clk(1);
        check("d0_data", {24'd0, fnd_data}, 32'h12);
        wait_clk(3);
        check("d1_com", {28'd0, fnd_com}, 32'hD);
        check("d1_data", {24'd0, fnd_data}, 32'hC0);
        wait_clk(4);
        check("d2_data", {24'd0, fnd_data}, 32'hF8);
        wait_clk(4);
        check("d3_data", {24'd0, fnd_data}, 32'hB0);

        // hour.min = 09.59 (k = 30 .. 35)
        mode = 1'b1; hour = 5'd9; min = 6'd59; dot = 4'hF;
        wait_clk(1);
        check("h_tens_data", {24'd0, fnd_data}, 32'hC0);
        wait_clk(3);
        check("m_units_com", {28'd0, fnd_com}, 32'hE);
        check("m_units_data", {24'd0, fnd_data}, 32'h90);
        mode = 1'b0;
        wait_clk(1);
        check("toggle_com", {28'd0, fnd_com}, 32'hE);
        check("toggle_data", {24'd0, fnd_data}, 32'h92);
        mode = 1'b1;
        wait_clk(1);
        check("toggle_back", {24'd0, fnd_data}, 32'h90);

        // Out-of-range msec = 127 (k = 36, 37)
        mode = 1'b0; msec = 7'd127;
        wait_clk(1);
        check("oor_units", {24'd0, fnd_data}, 32'hF8);
        wait_clk(1);
        check("oor_com", {28'd0, fnd_com}, 32'hD);
        check("oor_tens", {24'd0, fnd_data}, 32'hFF);

        // Reset during digit 2 (k = 42)
        wait_clk(5);
        check("pre_rst_com", {28'd0, fnd_com}, 32'hB);
        rst_n = 1'b0;
        wait_clk(1);
        check("mid_rst_com", {28'd0, fnd_com}, 32'hF);
        check("mid_rst_data", {24'd0, fnd_data}, 32'hFF);
        rst_n = 1'b1;
        wait_clk(1);
        check("restart_com", {28'd0, fnd_com}, 32'hE);

        // Reset landing exactly on a tick edge (4th clock of digit 0)
        wait_clk(2);
        rst_n = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        wait_clk(4);
        check("tick_rst_com", {28'd0, fnd_com}, 32'hE);

        // Free run with varied fields under the model
        mode = 1'b1; hour = 5'd23; min = 6'd7; dot = 4'h5;
        wait_clk(20);
        mode = 1'b0; sec = 6'd59; msec = 7'd99; dot = 4'hA;
        wait_clk(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
